morse_stream_encoder: RTL
=========================

# morse_stream_encoder

Streaming successor to the fixed 16-character Morse encoder. Accepts ASCII bytes on a valid/ready input with a message-end marker, buffers them in a small FIFO, and emits the line code serially on a valid/ready bit output: dot = 0, dash = 10, letter end = 11, word space = 1111. The block supports unbounded message length and reports per-message statistics. It sits between the text source (UART/keypad capture) and the keyer/transmit bit path.

## Interface
- FIFO_DEPTH, 4, input byte buffer entries; must be a power of 2 and at least 2.
- CNT_W, 16, width of the message bit counter.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input byte valid
- s_ready  out  1  input byte accepted when s_valid && s_ready
- s_data  in  8  ASCII character
- s_last  in  1  final character of the message
- m_valid  out  1  output bit valid
- m_ready  in  1  downstream accepts the bit
- m_bit  out  1  line-code bit
- m_last  out  1  final bit of the message
- busy  out  1  FIFO non-empty or FSM not in FETCH
- done  out  1  one-cycle pulse after m_last transfers
- msg_bits  out  CNT_W  total bits of the last completed message, saturating
- drop_count  out  8  unknown characters dropped since reset, saturating at 255

## Operation
- The FIFO stores {s_last, s_data}. s_ready = !full. There is no pass-through when full.
- Normalisation: 'a'..'z' map to 'A'..'Z' (subtract 32). Supported characters are A–Z, 0–9 and space (0x20). Every other character is unknown.
- Lookup returns {len (3 b), pattern (6 b, LSB = first element, 1 = dash)}, using the standard International Morse table.
- FSM states:
  - FETCH: wait for the FIFO to be non-empty. Then pop, normalise, look up, latch pattern/len/last, and go to:
    - SYM for a known character,
    - SPACE for a space,
    - GAP if the character is unknown and marked last,
    - FETCH if the character is unknown and not last (drop_count++).
  - SYM: emit elements in order. A dash takes two bits (sub-step flag). After the final element, go to GAP.
  - GAP: emit 1,1, then go to FETCH.
  - SPACE: emit 1,1,1,1, then go to FETCH. No letter-end bits are emitted for a space.
- m_last is asserted on the final bit of the character carrying last (second GAP bit, or fourth SPACE bit).
- The bit counter increments on every m_valid && m_ready, saturating at 2^CNT_W−1.
  - When m_last transfers, the counter value including that bit loads into msg_bits, the counter clears, and done pulses on the next cycle.
- Consecutive spaces each emit 1111. An unknown last character emits only the letter end 11 carrying m_last.

## Timing
- Reset values: s_ready=1, m_valid=0, m_bit=0, m_last=0, busy=0, done=0, msg_bits=0, drop_count=0. The FIFO is emptied, the FSM enters FETCH, and the counter is cleared.
- Reset mid-message discards all buffered and partially emitted data. There is no completion pulse.
- m_valid, m_bit and m_last are decoded from registered state only, with no combinational path from m_ready. They are held stable while m_valid && !m_ready.
- Latency: a byte accepted in cycle 0 is visible to FETCH in cycle 1, and its first bit has m_valid high in cycle 2.
- Throughput: one bit per cycle with m_ready high. There is exactly one m_valid-low FETCH cycle between characters.
- A simultaneous push and pop in the same cycle is legal. The FIFO pointers wrap modulo FIFO_DEPTH.
- drop_count and the bit counter saturate and do not wrap.

## Configuration
- MORSE_PUNCT_EN defined: the lookup adds the following six-element codes:
  - '.' = .-.-.-
  - ',' = --..--
  - '?' = ..--..
  - '/' = -..-. (five elements)
- MORSE_PUNCT_EN undefined: these four characters are unknown and dropped. The pattern width stays 6 bits either way.

## Structure
- Package morse_pkg holds:
  - the FSM state enum,
  - the 3-bit length and 6-bit pattern typedefs,
  - the line-code constants (LETTER_END=2'b11, SPACE_CODE=4'b1111),
  - the normalise and lookup functions (lookup guarded by MORSE_PUNCT_EN).
- Sub-module morse_char_fifo is a parametrised 9-bit-wide synchronous FIFO with full/empty flags, instantiated once.

## Test plan
- "E" with last, m_ready=1 → bits 0,1,1; m_last on the third bit; done pulses; msg_bits=3; first bit 2 cycles after accept.
- "a b" (lowercase, last on 'b') → 0,1,0,1,1 | 1,1,1,1 | 1,0,0,0,0,1,1; msg_bits=16; one m_valid-low cycle between characters.
- "SOS" with m_ready toggling every cycle → the same 18-bit stream as with m_ready=1 (00011 10101011 00011); outputs stable while stalled.
- "E#T" then "E#" (last on '#') → 011 1011 with msg_bits=7, then 0,1,1,1,1 with m_last on bit 5; drop_count=2.
- FIFO_DEPTH=4, m_ready=0, six bytes offered → five accepted (one held by the FSM), s_ready low afterwards; assert rst_n mid-stream → all outputs return to reset values next edge.
- MORSE_PUNCT_EN defined, "?" last → 0,0,1,0,1,0,0,0,1,1, msg_bits=10. Undefined: "?" last → 1,1, drop_count=1.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types, line-code constants and character helpers for the Morse stream encoder.
// MORSE_PUNCT_EN adds '.', ',', '?' and '/' to the lookup table.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_SYM   = 2'd1,
        ST_GAP   = 2'd2,
        ST_SPACE = 2'd3
    } state_t;

    typedef logic [2:0] len_t;
    typedef logic [5:0] pat_t;

    typedef struct packed {
        logic known;
        len_t len;
        pat_t pat;
    } code_t;

    localparam logic [1:0] LETTER_END  = 2'b11;
    localparam logic [3:0] SPACE_CODE  = 4'b1111;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    function automatic logic [7:0] normalise(input logic [7:0] c);
        if (c >= 8'h61 && c <= 8'h7a) begin
            return c - 8'd32;
        end
        return c;
    endfunction

    function automatic code_t mk(input len_t len, input pat_t pat);
        code_t r;
        r.known = 1'b1;
        r.len   = len;
        r.pat   = pat;
        return r;
    endfunction

    // Pattern bit 0 is the first element sent; a set bit is a dash.
    function automatic code_t lookup(input logic [7:0] c);
        code_t r;
        r = '0;
        case (c)
            "A": r = mk(3'd2, 6'b000010);
            "B": r = mk(3'd4, 6'b000001);
            "C": r = mk(3'd4, 6'b000101);
            "D": r = mk(3'd3, 6'b000001);
            "E": r = mk(3'd1, 6'b000000);
            "F": r = mk(3'd4, 6'b000100);
            "G": r = mk(3'd3, 6'b000011);
            "H": r = mk(3'd4, 6'b000000);
            "I": r = mk(3'd2, 6'b000000);
            "J": r = mk(3'd4, 6'b001110);
            "K": r = mk(3'd3, 6'b000101);
            "L": r = mk(3'd4, 6'b000010);
            "M": r = mk(3'd2, 6'b000011);
            "N": r = mk(3'd2, 6'b000001);
            "O": r = mk(3'd3, 6'b000111);
            "P": r = mk(3'd4, 6'b000110);
            "Q": r = mk(3'd4, 6'b001011);
            "R": r = mk(3'd3, 6'b000010);
            "S": r = mk(3'd3, 6'b000000);
            "T": r = mk(3'd1, 6'b000001);
            "U": r = mk(3'd3, 6'b000100);
            "V": r = mk(3'd4, 6'b001000);
            "W": r = mk(3'd3, 6'b000110);
            "X": r = mk(3'd4, 6'b001001);
            "Y": r = mk(3'd4, 6'b001101);
            "Z": r = mk(3'd4, 6'b000011);
            "0": r = mk(3'd5, 6'b011111);
            "1": r = mk(3'd5, 6'b011110);
            "2": r = mk(3'd5, 6'b011100);
            "3": r = mk(3'd5, 6'b011000);
            "4": r = mk(3'd5, 6'b010000);
            "5": r = mk(3'd5, 6'b000000);
            "6": r = mk(3'd5, 6'b000001);
            "7": r = mk(3'd5, 6'b000011);
            "8": r = mk(3'd5, 6'b000111);
            "9": r = mk(3'd5, 6'b001111);
`ifdef MORSE_PUNCT_EN
            ".": r = mk(3'd6, 6'b101010);
            ",": r = mk(3'd6, 6'b110011);
            "?": r = mk(3'd6, 6'b001100);
            "/": r = mk(3'd5, 6'b001001);
`else
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/morse_char_fifo.sv
// Synchronous FIFO with full/empty flags; holds {last, ascii} for the encoder.
module morse_char_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/morse_stream_encoder.sv
// Streaming ASCII-to-Morse line-code encoder: byte FIFO, per-character FSM, message statistics.
// state    | meaning
// FETCH    | wait for a buffered byte, pop and classify it
// SYM      | emit dot (0) / dash (10) elements of the latched pattern
// GAP      | emit letter end 11
// SPACE    | emit word space 1111
module morse_stream_encoder
    import morse_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_bit,
    output logic             m_last,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] msg_bits,
    output logic [7:0]       drop_count
);
    logic [8:0]       fifo_rd;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [7:0]       ch;
    code_t            code;

    state_t           state_q;
    pat_t             pat_q;
    len_t             len_q;
    logic [2:0]       idx_q;
    logic             sub_q;
    logic [1:0]       step_q;
    logic             last_q;
    logic [CNT_W-1:0] cnt_q, msg_bits_q, cnt_inc;
    logic [7:0]       drop_q;
    logic             done_q;
    logic             dash;

    morse_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (s_valid),
        .wr_data_i ({s_last, s_data}),
        .pop_i     (fifo_pop),
        .rd_data_o (fifo_rd),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign s_ready    = !fifo_full;
    assign fifo_pop   = (state_q == ST_FETCH) && !fifo_empty;
    assign ch         = normalise(fifo_rd[7:0]);
    assign code       = lookup(ch);
    assign dash       = pat_q[idx_q];
    assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign busy       = !fifo_empty || (state_q != ST_FETCH);
    assign done       = done_q;
    assign msg_bits   = msg_bits_q;
    assign drop_count = drop_q;

    // Bit outputs depend on registered state only, so they hold while stalled.
    always_comb begin
        m_valid = 1'b0;
        m_bit   = 1'b0;
        m_last  = 1'b0;
        case (state_q)
            ST_SYM: begin
                m_valid = 1'b1;
                m_bit   = dash && !sub_q;
            end
            ST_GAP: begin
                m_valid = 1'b1;
                m_bit   = LETTER_END[step_q[0]];
                m_last  = last_q && (step_q == 2'd1);
            end
            ST_SPACE: begin
                m_valid = 1'b1;
                m_bit   = SPACE_CODE[step_q];
                m_last  = last_q && (step_q == 2'd3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            pat_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            sub_q      <= 1'b0;
            step_q     <= '0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
            msg_bits_q <= '0;
            drop_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_FETCH: begin
                    if (!fifo_empty) begin
                        last_q <= fifo_rd[8];
                        pat_q  <= code.pat;
                        len_q  <= code.len;
                        idx_q  <= '0;
                        sub_q  <= 1'b0;
                        step_q <= '0;
                        if (ch == ASCII_SPACE) begin
                            state_q <= ST_SPACE;
                        end else if (code.known) begin
                            state_q <= ST_SYM;
                        end else begin
                            // An unknown last character still has to close the message.
                            if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
                            state_q <= fifo_rd[8] ? ST_GAP : ST_FETCH;
                        end
                    end
                end
                ST_SYM: begin
                    if (m_ready) begin
                        if (dash && !sub_q) begin
                            sub_q <= 1'b1;
                        end else begin
                            sub_q <= 1'b0;
                            if (idx_q == len_q - 3'd1) state_q <= ST_GAP;
                            else                       idx_q   <= idx_q + 3'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (m_ready) begin
                        step_q <= step_q + 2'd1;
                        if (step_q == 2'd1) state_q <= ST_FETCH;
                    end
                end
                ST_SPACE: begin
                    if (m_ready) begin
                        step_q <= step_q + 2'd1;
                        if (step_q == 2'd3) state_q <= ST_FETCH;
                    end
                end
                default: state_q <= ST_FETCH;
            endcase

            if (m_valid && m_ready) begin
                if (m_last) begin
                    msg_bits_q <= cnt_inc;
                    cnt_q      <= '0;
                    done_q     <= 1'b1;
                end else begin
                    cnt_q <= cnt_inc;
                end
            end
        end
    end

endmodule
